calc_op_sequencer: RTL

//  Sequencing controller for the 4-bit calculator datapath: accepts one operation request
//  (opcode + operands) over a valid/ready handshake, runs it, and holds the 8-bit result.
//  ADD/SUB/MUL/PCT complete in one execute cycle. DIV runs as an iterative restoring divider.
//  POW runs as repeated multiplication. Sits between the operand/key front-end and display.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/calc_div_iter.sv | 86 ++++++++
 rtl/calc_op_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and defaults for the 4-bit calculator sequencer and its iterative divider.
// Opcode decoding lives here so every block maps the raw 3-bit code the same way.
package calc_pkg;

    localparam int DEF_W       = 4;
    localparam int DEF_PCT_DIV = 100;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_POW = 3'd4,
        OP_PCT = 3'd5,
        OP_ILL = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Codes 6 and 7 both collapse onto OP_ILL.
    function automatic op_e decode_op(input logic [2:0] code);
        case (code)
            3'd0:    return OP_ADD;
            3'd1:    return OP_SUB;
            3'd2:    return OP_MUL;
            3'd3:    return OP_DIV;
            3'd4:    return OP_POW;
            3'd5:    return OP_PCT;
            default: return OP_ILL;
        endcase
    endfunction

endpackage

// File: rtl/calc_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, W cycles per run.
// done is high during the final step; quot/rem then carry that step's results.
module calc_div_iter
    import calc_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  divisor_q, divisor_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic [W-1:0]  step_quot;
    logic [W-1:0]  step_rem;

    // Partial remainder is shifted left by one dividend bit (held in the quotient
    // register), then the divisor is subtracted; a borrow means restore.
    always_comb begin
        shifted   = {rem_q, quot_q[W-1]};
        trial     = shifted - {1'b0, divisor_q};
        step_quot = {quot_q[W-2:0], ~trial[W]};
        step_rem  = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        if (start) begin
            quot_d    = dividend;
            rem_d     = '0;
            divisor_d = divisor;
            cnt_d     = CW'(W);
            busy_d    = 1'b1;
        end else if (busy_q) begin
            quot_d = step_quot;
            rem_d  = step_rem;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(1));
    assign quot = step_quot;
    assign rem  = step_rem;

endmodule

// File: rtl/calc_op_sequencer.sv
// Sequencing controller for the calculator datapath: accepts one request, runs it in EXEC,
// and presents the registered result one cycle after entering DONE until it is taken.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int PCT_DIV = DEF_PCT_DIV
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] resul,
    output logic           err,
    output logic           ovf
);

    localparam logic [2*W-1:0] ONES      = '1;
    localparam logic [2*W-1:0] PCT_DIV_W = (2*W)'(PCT_DIV);

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   pow_cnt_q, pow_cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic           sat_q, sat_d;
    logic [2*W-1:0] res_q, res_d;
    logic           err_q, err_d;
    logic           ovf_q, ovf_d;
    logic           out_valid_q, out_valid_d;

    op_e            req_op;
    logic           div_start;
    logic           div_busy;
    logic           div_done;
    logic [W-1:0]   div_quot;
    logic [W-1:0]   div_rem;

    logic [2*W-1:0] a_ext, b_ext;
    logic [2*W-1:0] mul_res;
    logic [3*W-1:0] pow_prod;
    logic           pow_sat;

    assign req_op    = decode_op(op);
    assign in_ready  = (state_q == IDLE) && !div_busy;
    assign div_start = in_ready && in_valid && (req_op == OP_DIV) && (b != '0);

    calc_div_iter #(.W(W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (a),
        .divisor  (b),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    // A POW step saturates when the product spills above 2W bits; the flag is sticky.
    always_comb begin
        a_ext    = {{W{1'b0}}, a_q};
        b_ext    = {{W{1'b0}}, b_q};
        mul_res  = a_ext * b_ext;
        pow_prod = {{W{1'b0}}, acc_q} * {{(2*W){1'b0}}, a_q};
        pow_sat  = sat_q | (|pow_prod[3*W-1:2*W]);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        pow_cnt_d   = pow_cnt_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        res_d       = res_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (in_valid && in_ready) begin
                    state_d   = EXEC;
                    op_d      = req_op;
                    a_d       = a;
                    b_d       = b;
                    acc_d     = {{(2*W-1){1'b0}}, 1'b1};
                    pow_cnt_d = b;
                    sat_d     = 1'b0;
                end
            end

            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        res_d   = a_ext + b_ext;
                        state_d = DONE;
                    end
                    OP_SUB: begin
                        res_d   = a_ext - b_ext;
                        state_d = DONE;
                    end
                    OP_MUL: begin
                        res_d   = mul_res;
                        state_d = DONE;
                    end
                    OP_PCT: begin
                        res_d   = mul_res / PCT_DIV_W;
                        state_d = DONE;
                    end
                    OP_DIV: begin
                        if (b_q == '0) begin
                            res_d   = ONES;
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else if (div_done) begin
                            res_d   = {div_rem, div_quot};
                            state_d = DONE;
                        end
                    end
                    OP_POW: begin
                        // b=0 still spends one EXEC cycle and leaves acc at 1.
                        if (pow_cnt_q != '0) begin
                            acc_d     = pow_prod[2*W-1:0];
                            sat_d     = pow_sat;
                            pow_cnt_d = pow_cnt_q - 1'b1;
                        end
                        if (pow_cnt_q <= W'(1)) begin
                            ovf_d   = sat_d;
                            res_d   = sat_d ? ONES : acc_d;
                            state_d = DONE;
                        end
                    end
                    default: begin
                        res_d   = ONES;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                endcase
            end

            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    res_d       = '0;
                    err_d       = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            pow_cnt_q   <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            res_q       <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pow_cnt_q   <= pow_cnt_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            res_q       <= res_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign resul     = res_q;
    assign err       = err_q;
    assign ovf       = ovf_q;

endmodule
